// File: rtl/field_seq_pkg.sv
// Shared geometry, FSM encoding and field decode helpers for the field
// sequencing arbiter.
package field_seq_pkg;

  localparam int FIELD_W = 8;
  localparam int TAIL_W  = 15;
  localparam int NFIELD  = 26;
  localparam int RW      = TAIL_W + (NFIELD - 1) * FIELD_W;
  localparam int IDX_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Field 0 is the wide tail at the bottom; byte fields follow it upward.
  function automatic int field_lsb(input int idx, input int tail_w, input int field_w);
    return (idx == 0) ? 0 : tail_w + (idx - 1) * field_w;
  endfunction

  function automatic int field_width(input int idx, input int tail_w, input int field_w);
    return (idx == 0) ? tail_w : field_w;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant: prio names the requester that wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = prio ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/field_seq_arbiter.sv
// Two writers update fields of a working record through a round-robin
// arbiter; commit snapshots the record to out via a shadow copy.
module field_seq_arbiter #(
  parameter int FIELD_W = field_seq_pkg::FIELD_W,
  parameter int TAIL_W  = field_seq_pkg::TAIL_W,
  parameter int NFIELD  = field_seq_pkg::NFIELD
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [1:0]                            req,
  input  logic [4:0]                            idx0,
  input  logic [4:0]                            idx1,
  input  logic [TAIL_W-1:0]                     data0,
  input  logic [TAIL_W-1:0]                     data1,
  input  logic                                  commit,
  output logic [1:0]                            gnt,
  output logic                                  busy,
  output logic [TAIL_W+(NFIELD-1)*FIELD_W-1:0]  out,
  output logic                                  out_valid,
  output logic                                  err
);

  import field_seq_pkg::*;

  localparam int             REC_W   = TAIL_W + (NFIELD - 1) * FIELD_W;
  localparam logic [4:0]     MAX_IDX = 5'(NFIELD - 1);

  state_t              state_reg, state_next;
  logic [REC_W-1:0]    work_reg, work_next;
  logic [REC_W-1:0]    shadow_reg;
  logic [REC_W-1:0]    out_reg;
  logic                out_valid_reg;
  logic                err_reg, err_next;
  logic                prio_reg;

  logic                arb_en;
  logic                copy_en;
  logic                out_en;
  logic [1:0]          arb_gnt;
  logic [4:0]          wr_idx;
  logic [TAIL_W-1:0]   wr_data;
  logic                wr_any;
  logic                wr_ok;

  rr_arb2 u_arb (
    .req  (req),
    .prio (prio_reg),
    .gnt  (arb_gnt)
  );

  always_comb begin
    state_next = state_reg;
    arb_en     = 1'b0;
    copy_en    = 1'b0;
    out_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (commit) state_next = COPY;
        else        arb_en     = 1'b1;
      end
      COPY: begin
        copy_en    = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        out_en     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign gnt  = (rst_n && arb_en) ? arb_gnt : 2'b00;
  assign busy = (state_reg == COPY) || (state_reg == OUT);

  always_comb begin
    wr_idx   = gnt[1] ? idx1 : idx0;
    wr_data  = gnt[1] ? data1 : data0;
    wr_any   = |gnt;
    wr_ok    = wr_any && (wr_idx <= MAX_IDX);
    err_next = wr_any && (wr_idx > MAX_IDX);
  end

  // Each field gets its own constant slice, so every bit of work_next has
  // exactly one driver and unselected fields pass through untouched.
  genvar gi;
  generate
    for (gi = 0; gi < NFIELD; gi++) begin : g_field
      localparam int LSB = field_lsb(gi, TAIL_W, FIELD_W);
      localparam int W   = field_width(gi, TAIL_W, FIELD_W);
      assign work_next[LSB +: W] = (wr_ok && (wr_idx == 5'(gi))) ? wr_data[W-1:0]
                                                                 : work_reg[LSB +: W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      work_reg      <= '0;
      shadow_reg    <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      prio_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      work_reg      <= work_next;
      out_valid_reg <= out_en;
      err_reg       <= err_next;
      if (copy_en) shadow_reg <= work_reg;
      if (out_en)  out_reg    <= shadow_reg;
      if (wr_any)  prio_reg   <= gnt[0];
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_field_seq_arbiter.sv
// Directed self-checking bench for field_seq_arbiter: grants, round-robin,
// commit latency, bad-index errors and reset abort.
module tb_field_seq_arbiter;

  import field_seq_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        req = 2'b00;
  logic [4:0]        idx0 = '0;
  logic [4:0]        idx1 = '0;
  logic [TAIL_W-1:0] data0 = '0;
  logic [TAIL_W-1:0] data1 = '0;
  logic              commit = 1'b0;
  logic [1:0]        gnt;
  logic              busy;
  logic [RW-1:0]     out;
  logic              out_valid;
  logic              err;

  int                errors = 0;
  int                checks = 0;
  logic [RW-1:0]     exp_rec;
  logic [1:0]        rr_seq [4];

  always #5 clk = ~clk;

  field_seq_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .idx0      (idx0),
    .idx1      (idx1),
    .data0     (data0),
    .data1     (data1),
    .commit    (commit),
    .gnt       (gnt),
    .busy      (busy),
    .out       (out),
    .out_valid (out_valid),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit_and_check(input string tag, input logic [RW-1:0] expv);
    commit = 1'b1;
    #1;
    chk({tag, "_gnt_commit"}, RW'(gnt), RW'(2'b00));
    tick();
    commit = 1'b0;
    chk({tag, "_busy_copy"}, RW'(busy), RW'(1'b1));
    chk({tag, "_ov_copy"}, RW'(out_valid), RW'(1'b0));
    tick();
    chk({tag, "_busy_out"}, RW'(busy), RW'(1'b1));
    tick();
    chk({tag, "_ov_pulse"}, RW'(out_valid), RW'(1'b1));
    chk({tag, "_out"}, out, expv);
    chk({tag, "_busy_idle"}, RW'(busy), RW'(1'b0));
    tick();
    chk({tag, "_ov_drop"}, RW'(out_valid), RW'(1'b0));
    $display("commit %s out=%0h", tag, out);
  endtask

  initial begin
    rr_seq[0] = 2'b01;
    rr_seq[1] = 2'b10;
    rr_seq[2] = 2'b01;
    rr_seq[3] = 2'b10;

    // Reset state, with both requests pending to show gnt is held off.
    req = 2'b11;
    #12;
    chk("rst_gnt", RW'(gnt), RW'(2'b00));
    chk("rst_out", out, '0);
    chk("rst_ov", RW'(out_valid), RW'(1'b0));
    chk("rst_err", RW'(err), RW'(1'b0));
    chk("rst_busy", RW'(busy), RW'(1'b0));
    $display("reset checked");

    // Single write to the top byte field, then commit.
    @(negedge clk);
    rst_n = 1'b1;
    req   = 2'b01;
    idx0  = 5'd25;
    data0 = 15'h0019;
    #1;
    chk("top_gnt", RW'(gnt), RW'(2'b01));
    tick();
    req = 2'b00;
    exp_rec = '0;
    exp_rec[214:207] = 8'h19;
    commit_and_check("top", exp_rec);

    // Fresh reset so prio starts at 0, then hold both requests.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    chk("rst2_out", out, '0);
    req   = 2'b11;
    idx0  = 5'd2;
    data0 = 15'h00AA;
    idx1  = 5'd3;
    data1 = 15'h0155;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_gnt%0d", i), RW'(gnt), RW'(rr_seq[i]));
      $display("rr cycle %0d gnt=%b", i, gnt);
      tick();
    end
    req = 2'b00;
    exp_rec = '0;
    exp_rec[30:23] = 8'hAA;
    exp_rec[38:31] = 8'h55;
    commit_and_check("rr", exp_rec);

    // Commit wins over a simultaneous request; request granted once idle.
    req    = 2'b01;
    commit = 1'b1;
    idx0   = 5'd4;
    data0  = 15'h003C;
    #1;
    chk("cw_gnt0", RW'(gnt), RW'(2'b00));
    tick();
    commit = 1'b0;
    chk("cw_busy1", RW'(busy), RW'(1'b1));
    chk("cw_gnt1", RW'(gnt), RW'(2'b00));
    tick();
    chk("cw_busy2", RW'(busy), RW'(1'b1));
    chk("cw_gnt2", RW'(gnt), RW'(2'b00));
    tick();
    chk("cw_ov", RW'(out_valid), RW'(1'b1));
    chk("cw_out", out, exp_rec);
    chk("cw_busy3", RW'(busy), RW'(1'b0));
    chk("cw_gnt3", RW'(gnt), RW'(2'b01));
    $display("commit-wins gnt=%b", gnt);
    tick();
    req = 2'b00;
    exp_rec[46:39] = 8'h3C;

    // Out-of-range index: granted, no write, one-cycle err.
    req   = 2'b10;
    idx1  = 5'd30;
    data1 = 15'h7FFF;
    #1;
    chk("bad_gnt", RW'(gnt), RW'(2'b10));
    tick();
    req = 2'b00;
    chk("bad_err1", RW'(err), RW'(1'b1));
    tick();
    chk("bad_err2", RW'(err), RW'(1'b0));
    $display("bad index err pulse seen");
    req   = 2'b11;
    idx0  = 5'd2;
    data0 = 15'h00AA;
    #1;
    chk("bad_prio", RW'(gnt), RW'(2'b01));
    tick();
    req = 2'b00;
    commit_and_check("bad", exp_rec);

    // Wide tail field and byte field with ignored upper data bits.
    req   = 2'b01;
    idx0  = 5'd0;
    data0 = 15'h7FFF;
    tick();
    req   = 2'b10;
    idx1  = 5'd1;
    data1 = 15'h01FF;
    tick();
    req = 2'b00;
    exp_rec[14:0]  = 15'h7FFF;
    exp_rec[22:15] = 8'hFF;
    commit_and_check("tail", exp_rec);

    // Reset during COPY aborts the commit.
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("abort_busy", RW'(busy), RW'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("abort_out", out, '0);
    chk("abort_ov", RW'(out_valid), RW'(1'b0));
    chk("abort_busy0", RW'(busy), RW'(1'b0));
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("abort_ov%0d", i), RW'(out_valid), RW'(1'b0));
      chk($sformatf("abort_outq%0d", i), out, '0);
    end
    $display("reset abort checked");
    req   = 2'b01;
    idx0  = 5'd5;
    data0 = 15'h0011;
    #1;
    chk("abort_gnt", RW'(gnt), RW'(2'b01));
    tick();
    req = 2'b00;
    exp_rec = '0;
    exp_rec[54:47] = 8'h11;
    commit_and_check("post", exp_rec);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
